// File: rtl/clk_div_pkg.sv
// Shared state encoding, default ratio and configuration record for the
// fractional clock-enable scheduler.
package clk_div_pkg;

   localparam int CLK_DIV_CNT_WIDTH = 8;
   localparam int CLK_DIV_DEF_NUM   = 2;
   localparam int CLK_DIV_DEF_DEN   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

   // Ratio record at the default width, as seen by the clock-management registers.
   typedef struct packed {
      logic [CLK_DIV_CNT_WIDTH-1:0] num;
      logic [CLK_DIV_CNT_WIDTH-1:0] den;
   } cfg_t;

endpackage

// File: rtl/clk_div_ctrl_frac_acc.sv
// Fractional accumulator plus period cycle counter; flags the pulse and
// boundary decisions for the current step.
module frac_acc
   import clk_div_pkg::*;
#(
   parameter int CNT_WIDTH = CLK_DIV_CNT_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 step_i,
   input  logic [CNT_WIDTH-1:0] num_i,
   input  logic [CNT_WIDTH-1:0] den_i,
   output logic                 pulse_o,
   output logic                 boundary_o
);

   logic [CNT_WIDTH:0]   acc_q, acc_d, sum;
   logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
   logic                 overflow, wrap;

   // acc stays below den, so acc+num fits in CNT_WIDTH+1 bits and returns to 0 on every wrap.
   always_comb begin
      sum        = acc_q + {1'b0, num_i};
      overflow   = (sum >= {1'b0, den_i});
      wrap       = (cyc_q == den_i - 1'b1);
      pulse_o    = step_i && overflow;
      boundary_o = step_i && wrap;
      acc_d      = acc_q;
      cyc_d      = cyc_q;
      if (clear_i) begin
         acc_d = '0;
         cyc_d = '0;
      end else if (step_i) begin
         acc_d = overflow ? (sum - {1'b0, den_i}) : sum;
         cyc_d = wrap ? '0 : (cyc_q + 1'b1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
         cyc_q <= '0;
      end else begin
         acc_q <= acc_d;
         cyc_q <= cyc_d;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable NUM/DEN clock-enable scheduler: run/stop sequencing and a
// valid/ready ratio port whose changes land only on period boundaries.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_WIDTH = CLK_DIV_CNT_WIDTH,
   parameter int DEF_NUM   = CLK_DIV_DEF_NUM,
   parameter int DEF_DEN   = CLK_DIV_DEF_DEN
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 run,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CNT_WIDTH-1:0] cfg_num,
   input  logic [CNT_WIDTH-1:0] cfg_den,
   output logic                 cfg_err,
   output logic                 clk_en,
   output logic                 period_tick,
   output logic                 active
);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cur_num_q, cur_den_q, pend_num_q, pend_den_q;
   logic                 pend_valid_q, cfg_ready_q, cfg_err_q;
   logic                 clk_en_q, period_tick_q, active_q;
   logic                 running, cfg_fire, cfg_legal, acc_pulse, acc_boundary;

   assign running   = (state_q != IDLE);
   assign cfg_fire  = cfg_valid && cfg_ready_q;
   assign cfg_legal = (cfg_num != '0) && (cfg_num <= cfg_den);

   frac_acc #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_frac_acc (
      .clk_i      (sys_clk),
      .rst_i      (sys_rst),
      .clear_i    (!running),
      .step_i     (running),
      .num_i      (cur_num_q),
      .den_i      (cur_den_q),
      .pulse_o    (acc_pulse),
      .boundary_o (acc_boundary)
   );

   // STOP finishes the current period unless run comes back first.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (run) state_d = RUN;
         RUN:     if (!run) state_d = acc_boundary ? IDLE : STOP;
         STOP: begin
            if (run)               state_d = RUN;
            else if (acc_boundary) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= IDLE;
         clk_en_q      <= 1'b0;
         period_tick_q <= 1'b0;
         active_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         clk_en_q      <= acc_pulse;
         period_tick_q <= acc_boundary;
         active_q      <= running;
      end
   end

   // A held-off ratio is only accepted while nothing is pending, so a new
   // transfer and a pending swap can never coincide.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cur_num_q    <= CNT_WIDTH'(DEF_NUM);
         cur_den_q    <= CNT_WIDTH'(DEF_DEN);
         pend_num_q   <= '0;
         pend_den_q   <= '0;
         pend_valid_q <= 1'b0;
         cfg_ready_q  <= 1'b1;
         cfg_err_q    <= 1'b0;
      end else begin
         cfg_err_q <= cfg_fire && !cfg_legal;
         if (cfg_fire && cfg_legal && !running) begin
            cur_num_q <= cfg_num;
            cur_den_q <= cfg_den;
         end else if (cfg_fire && cfg_legal) begin
            pend_num_q   <= cfg_num;
            pend_den_q   <= cfg_den;
            pend_valid_q <= 1'b1;
            cfg_ready_q  <= 1'b0;
         end else if (pend_valid_q && (acc_boundary || !running)) begin
            cur_num_q    <= pend_num_q;
            cur_den_q    <= pend_den_q;
            pend_valid_q <= 1'b0;
            cfg_ready_q  <= 1'b1;
         end
      end
   end

   assign cfg_ready   = cfg_ready_q;
   assign cfg_err     = cfg_err_q;
   assign clk_en      = clk_en_q;
   assign period_tick = period_tick_q;
   assign active      = active_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: cycle-indexed output masks compared against
// hand-derived patterns for each scenario.
module tb_clk_div_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst, run, cfg_valid;
   logic [7:0] cfg_num, cfg_den;
   logic       cfg_ready, cfg_err, clk_en, period_tick, active;

   int checks   = 0;
   int failures = 0;

   logic [15:0] capEn, capTick, capAct, capRdy, capErr;

   clk_div_ctrl #(
      .CNT_WIDTH (8),
      .DEF_NUM   (2),
      .DEF_DEN   (3)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .run         (run),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_num     (cfg_num),
      .cfg_den     (cfg_den),
      .cfg_err     (cfg_err),
      .clk_en      (clk_en),
      .period_tick (period_tick),
      .active      (active)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "[TB] timeout");
   end

   task automatic nextCycle;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic capture(input int c);
      capEn[c]   = clk_en;
      capTick[c] = period_tick;
      capAct[c]  = active;
      capRdy[c]  = cfg_ready;
      capErr[c]  = cfg_err;
   endtask

   // Leaves the bench in cycle 0: reset was sampled at the last edge.
   task automatic resetDut;
      sys_rst   = 1'b1;
      run       = 1'b0;
      cfg_valid = 1'b0;
      cfg_num   = 8'd0;
      cfg_den   = 8'd0;
      nextCycle;
      nextCycle;
      sys_rst = 1'b0;
   endtask

   task automatic test_reset;
      sys_rst   = 1'b1;
      run       = 1'b1;
      cfg_valid = 1'b1;
      cfg_num   = 8'd5;
      cfg_den   = 8'd3;
      nextCycle;
      nextCycle;
      nextCycle;
      checks++; if (clk_en !== 1'b0) begin failures++; $display("[TB] FAIL reset clk_en: got %b expected 0", clk_en); end
      checks++; if (period_tick !== 1'b0) begin failures++; $display("[TB] FAIL reset period_tick: got %b expected 0", period_tick); end
      checks++; if (active !== 1'b0) begin failures++; $display("[TB] FAIL reset active: got %b expected 0", active); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset cfg_ready: got %b expected 1", cfg_ready); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL reset cfg_err: got %b expected 0", cfg_err); end
      sys_rst   = 1'b0;
      run       = 1'b0;
      cfg_valid = 1'b0;
   endtask

   task automatic test_default_pattern;
      resetDut;
      for (int c = 0; c < 16; c++) begin
         capture(c);
         if (c == 0) run = 1'b1;
         nextCycle;
      end
      checks++; if (capEn !== 16'hB6D8) begin failures++; $display("[TB] FAIL default clk_en: got %h expected %h", capEn, 16'hB6D8); end
      checks++; if (capTick !== 16'h2490) begin failures++; $display("[TB] FAIL default period_tick: got %h expected %h", capTick, 16'h2490); end
      checks++; if (capAct !== 16'hFFFC) begin failures++; $display("[TB] FAIL default active: got %h expected %h", capAct, 16'hFFFC); end
      checks++; if (capRdy !== 16'hFFFF) begin failures++; $display("[TB] FAIL default cfg_ready: got %h expected %h", capRdy, 16'hFFFF); end
   endtask

   task automatic test_cfg_change;
      resetDut;
      for (int c = 0; c < 16; c++) begin
         capture(c);
         if (c == 0) run = 1'b1;
         if (c == 4) begin cfg_valid = 1'b1; cfg_num = 8'd1; cfg_den = 8'd4; end
         if (c == 5) cfg_valid = 1'b0;
         nextCycle;
      end
      checks++; if (capEn !== 16'h88D8) begin failures++; $display("[TB] FAIL cfg_change clk_en: got %h expected %h", capEn, 16'h88D8); end
      checks++; if (capTick !== 16'h8890) begin failures++; $display("[TB] FAIL cfg_change period_tick: got %h expected %h", capTick, 16'h8890); end
      checks++; if (capRdy !== 16'hFF9F) begin failures++; $display("[TB] FAIL cfg_change cfg_ready: got %h expected %h", capRdy, 16'hFF9F); end
      checks++; if (capErr !== 16'h0000) begin failures++; $display("[TB] FAIL cfg_change cfg_err: got %h expected %h", capErr, 16'h0000); end
   endtask

   task automatic test_illegal_cfg;
      resetDut;
      for (int c = 0; c < 16; c++) begin
         capture(c);
         if (c == 0) run = 1'b1;
         if (c == 2) begin cfg_valid = 1'b1; cfg_num = 8'd3; cfg_den = 8'd2; end
         if (c == 3) begin cfg_num = 8'd0; cfg_den = 8'd5; end
         if (c == 4) cfg_valid = 1'b0;
         nextCycle;
      end
      checks++; if (capErr !== 16'h0018) begin failures++; $display("[TB] FAIL illegal cfg_err: got %h expected %h", capErr, 16'h0018); end
      checks++; if (capEn !== 16'hB6D8) begin failures++; $display("[TB] FAIL illegal clk_en: got %h expected %h", capEn, 16'hB6D8); end
      checks++; if (capTick !== 16'h2490) begin failures++; $display("[TB] FAIL illegal period_tick: got %h expected %h", capTick, 16'h2490); end
      checks++; if (capRdy !== 16'hFFFF) begin failures++; $display("[TB] FAIL illegal cfg_ready: got %h expected %h", capRdy, 16'hFFFF); end
   endtask

   task automatic test_stop;
      resetDut;
      for (int c = 0; c < 16; c++) begin
         capture(c);
         if (c == 0) run = 1'b1;
         if (c == 5) run = 1'b0;
         nextCycle;
      end
      checks++; if (capEn !== 16'h00D8) begin failures++; $display("[TB] FAIL stop clk_en: got %h expected %h", capEn, 16'h00D8); end
      checks++; if (capTick !== 16'h0090) begin failures++; $display("[TB] FAIL stop period_tick: got %h expected %h", capTick, 16'h0090); end
      checks++; if (capAct !== 16'h00FC) begin failures++; $display("[TB] FAIL stop active: got %h expected %h", capAct, 16'h00FC); end
   endtask

   task automatic test_stop_resume;
      resetDut;
      for (int c = 0; c < 16; c++) begin
         capture(c);
         if (c == 0) run = 1'b1;
         if (c == 4) run = 1'b0;
         if (c == 5) run = 1'b1;
         nextCycle;
      end
      checks++; if (capEn !== 16'hB6D8) begin failures++; $display("[TB] FAIL resume clk_en: got %h expected %h", capEn, 16'hB6D8); end
      checks++; if (capTick !== 16'h2490) begin failures++; $display("[TB] FAIL resume period_tick: got %h expected %h", capTick, 16'h2490); end
      checks++; if (capAct !== 16'hFFFC) begin failures++; $display("[TB] FAIL resume active: got %h expected %h", capAct, 16'hFFFC); end
   endtask

   task automatic test_full_rate;
      resetDut;
      for (int c = 0; c < 16; c++) begin
         capture(c);
         if (c == 0) begin run = 1'b1; cfg_valid = 1'b1; cfg_num = 8'd4; cfg_den = 8'd4; end
         if (c == 1) cfg_valid = 1'b0;
         nextCycle;
      end
      checks++; if (capEn !== 16'hFFFC) begin failures++; $display("[TB] FAIL full_rate clk_en: got %h expected %h", capEn, 16'hFFFC); end
      checks++; if (capTick !== 16'h2220) begin failures++; $display("[TB] FAIL full_rate period_tick: got %h expected %h", capTick, 16'h2220); end
      checks++; if (capRdy !== 16'hFFFF) begin failures++; $display("[TB] FAIL full_rate cfg_ready: got %h expected %h", capRdy, 16'hFFFF); end
   endtask

   task automatic test_slow_rate;
      int enCount   = 0;
      int bothCount = 0;
      int firstEn   = -1;
      resetDut;
      run       = 1'b1;
      cfg_valid = 1'b1;
      cfg_num   = 8'd1;
      cfg_den   = 8'd255;
      nextCycle;
      cfg_valid = 1'b0;
      for (int c = 1; c <= 520; c++) begin
         if (clk_en === 1'b1) begin
            enCount++;
            if (firstEn < 0) firstEn = c;
            if (period_tick === 1'b1) bothCount++;
         end
         nextCycle;
      end
      checks++; if (firstEn != 256) begin failures++; $display("[TB] FAIL slow first_pulse: got %0d expected 256", firstEn); end
      checks++; if (enCount != 2) begin failures++; $display("[TB] FAIL slow pulse_count: got %0d expected 2", enCount); end
      checks++; if (bothCount != 2) begin failures++; $display("[TB] FAIL slow pulse_on_boundary: got %0d expected 2", bothCount); end
   endtask

   task automatic test_reset_midop;
      resetDut;
      for (int c = 0; c < 6; c++) begin
         capture(c);
         if (c == 0) run = 1'b1;
         if (c == 4) begin cfg_valid = 1'b1; cfg_num = 8'd1; cfg_den = 8'd4; end
         if (c == 5) begin cfg_valid = 1'b0; sys_rst = 1'b1; end
         nextCycle;
      end
      checks++; if (capRdy[5] !== 1'b0) begin failures++; $display("[TB] FAIL midrst pending_before: got %b expected 0", capRdy[5]); end
      checks++; if (clk_en !== 1'b0) begin failures++; $display("[TB] FAIL midrst clk_en: got %b expected 0", clk_en); end
      checks++; if (active !== 1'b0) begin failures++; $display("[TB] FAIL midrst active: got %b expected 0", active); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst cfg_ready: got %b expected 1", cfg_ready); end
      sys_rst = 1'b0;
      for (int c = 0; c < 16; c++) begin
         capture(c);
         nextCycle;
      end
      checks++; if (capEn !== 16'hB6D8) begin failures++; $display("[TB] FAIL midrst restart clk_en: got %h expected %h", capEn, 16'hB6D8); end
      checks++; if (capTick !== 16'h2490) begin failures++; $display("[TB] FAIL midrst restart period_tick: got %h expected %h", capTick, 16'h2490); end
   endtask

   initial begin
      sys_rst   = 1'b1;
      run       = 1'b0;
      cfg_valid = 1'b0;
      cfg_num   = 8'd0;
      cfg_den   = 8'd0;
      test_reset;
      test_default_pattern;
      test_cfg_change;
      test_illegal_cfg;
      test_stop;
      test_stop_resume;
      test_full_rate;
      test_slow_rate;
      test_reset_midop;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
